modn_counter: RTL and testbench

- Parametrised up/down modulo-N counter; the general replacement for the fixed mod-7 counter.
- Adds:
  - programmable step size
  - synchronous load and clear
  - wrap or saturate mode
  - terminal-count, wrap and saturation flags
  - running wrap-event counter
- Used as a sequencer/index generator wherever a bounded cyclic count with direction control is needed.

---
 rtl/modn_pkg.sv | 19 +
 rtl/modn_counter_if.sv | 36 +++
 rtl/modn_next.sv | 65 ++++++
 rtl/modn_counter.sv | 94 +++++++++
 tb/tb_modn_counter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/modn_pkg.sv
// Shared types and width helper for the modulo-N counter family.
package modn_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Width needed to hold 0..modulus-1; never narrower than one bit.
  function automatic int modn_width(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/modn_counter_if.sv
// Control and status bundle of the modulo-N counter; the master drives controls, the counter is the slave.
interface modn_counter_if
  import modn_pkg::*;
#(
  parameter int MODULUS = 7,
  parameter int WRAP_W  = 8
) ();

  localparam int W = modn_width(MODULUS);

  logic              clr;
  logic              now;
  dir_e              dir;
  mode_e             mode;
  logic [W-1:0]      step;
  logic              load;
  logic [W-1:0]      load_val;

  logic [W-1:0]      value;
  logic              tc;
  logic              wrap;
  logic              sat;
  logic              err;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output clr, now, dir, mode, step, load, load_val,
    input  value, tc, wrap, sat, err, wrap_cnt
  );

  modport slave (
    input  clr, now, dir, mode, step, load, load_val,
    output value, tc, wrap, sat, err, wrap_cnt
  );

endinterface

// File: rtl/modn_next.sv
// Combinational next-value generator for one enabled count step, with wrap/saturate/error events.
module modn_next
  import modn_pkg::*;
#(
  parameter int MODULUS = 7,
  parameter int W       = modn_width(MODULUS)
) (
  input  logic [W-1:0] value_i,
  input  dir_e         dir_i,
  input  mode_e        mode_i,
  input  logic [W-1:0] step_i,
  output logic [W-1:0] next_value_o,
  output logic         wrap_ev_o,
  output logic         sat_ev_o,
  output logic         step_err_o
);

  // One extra bit so value+step and value+MODULUS never overflow.
  localparam logic [W:0] MOD_C = (W+1)'(MODULUS);
  localparam logic [W:0] MAX_C = (W+1)'(MODULUS - 1);

  logic [W:0] val_x;
  logic [W:0] step_x;
  logic [W:0] up_sum;
  logic [W:0] res;

  always_comb begin
    val_x      = {1'b0, value_i};
    step_x     = {1'b0, step_i};
    up_sum     = val_x + step_x;
    res        = val_x;
    wrap_ev_o  = 1'b0;
    sat_ev_o   = 1'b0;
    step_err_o = 1'b0;

    if (step_x >= MOD_C) begin
      step_err_o = 1'b1;
    end else if (step_x != '0) begin
      if (dir_i == DIR_UP) begin
        if (up_sum < MOD_C) begin
          res = up_sum;
        end else if (mode_i == MODE_WRAP) begin
          res       = up_sum - MOD_C;
          wrap_ev_o = 1'b1;
        end else begin
          res      = MAX_C;
          sat_ev_o = 1'b1;
        end
      end else begin
        if (val_x >= step_x) begin
          res = val_x - step_x;
        end else if (mode_i == MODE_WRAP) begin
          res       = val_x + MOD_C - step_x;
          wrap_ev_o = 1'b1;
        end else begin
          res      = '0;
          sat_ev_o = 1'b1;
        end
      end
    end

    next_value_o = W'(res);
  end

endmodule

// File: rtl/modn_counter.sv
// Up/down modulo-N counter: registers, clear/load/count priority and the wrap-event counter.
module modn_counter
  import modn_pkg::*;
#(
  parameter int MODULUS = 7,
  parameter int WRAP_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  modn_counter_if.slave  bus
);

  localparam int W = modn_width(MODULUS);
  localparam logic [W:0]   MOD_C = (W+1)'(MODULUS);
  localparam logic [W-1:0] MAX_C = W'(MODULUS - 1);

  logic [W-1:0]      value_q, value_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              wrap_q, wrap_d;
  logic              sat_q, sat_d;
  logic              err_q, err_d;

  logic [W-1:0]      nxt_value;
  logic              nxt_wrap;
  logic              nxt_sat;
  logic              nxt_err;

  modn_next #(
    .MODULUS (MODULUS),
    .W       (W)
  ) u_next (
    .value_i      (value_q),
    .dir_i        (bus.dir),
    .mode_i       (bus.mode),
    .step_i       (bus.step),
    .next_value_o (nxt_value),
    .wrap_ev_o    (nxt_wrap),
    .sat_ev_o     (nxt_sat),
    .step_err_o   (nxt_err)
  );

  // Pulses default low every cycle; only the winning action may raise one.
  always_comb begin
    value_d    = value_q;
    wrap_cnt_d = wrap_cnt_q;
    wrap_d     = 1'b0;
    sat_d      = 1'b0;
    err_d      = 1'b0;

    if (bus.clr) begin
      value_d    = '0;
      wrap_cnt_d = '0;
    end else if (bus.load) begin
      if ({1'b0, bus.load_val} < MOD_C) begin
        value_d = bus.load_val;
      end else begin
        value_d = MAX_C;
        err_d   = 1'b1;
      end
    end else if (bus.now) begin
      value_d = nxt_value;
      wrap_d  = nxt_wrap;
      sat_d   = nxt_sat;
      err_d   = nxt_err;
      if (nxt_wrap) begin
        wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q    <= '0;
      wrap_cnt_q <= '0;
      wrap_q     <= 1'b0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      value_q    <= value_d;
      wrap_cnt_q <= wrap_cnt_d;
      wrap_q     <= wrap_d;
      sat_q      <= sat_d;
      err_q      <= err_d;
    end
  end

  assign bus.value    = value_q;
  assign bus.wrap_cnt = wrap_cnt_q;
  assign bus.wrap     = wrap_q;
  assign bus.sat      = sat_q;
  assign bus.err      = err_q;
  assign bus.tc       = (bus.dir == DIR_UP) ? (value_q == MAX_C) : (value_q == '0);

endmodule

// File: tb/tb_modn_counter.sv
// Scoreboard bench for modn_counter (MODULUS=7): directed scenarios then random stimulus vs an arithmetic model.
module tb_modn_counter;
  import modn_pkg::*;

  localparam int M  = 7;
  localparam int WW = 8;
  localparam int W  = modn_width(M);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  modn_counter_if #(.MODULUS(M), .WRAP_W(WW)) bus ();

  modn_counter #(.MODULUS(M), .WRAP_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int value;
    bit wrap;
    bit sat;
    bit err;
    bit tc;
    int wcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   n_txn  = 0;
  int   m_value = 0;
  int   m_wcnt  = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference model: plain modular arithmetic on integers, one call per driven edge.
  task automatic apply(input bit c, input bit ld, input int lv, input bit nw,
                       input bit d, input bit md, input int st);
    exp_t e;
    int   s;
    bus.clr      = c;
    bus.load     = ld;
    bus.load_val = W'(lv);
    bus.now      = nw;
    bus.dir      = d ? DIR_UP : DIR_DOWN;
    bus.mode     = md ? MODE_SAT : MODE_WRAP;
    bus.step     = W'(st);
    e.wrap = 0;
    e.sat  = 0;
    e.err  = 0;
    if (c) begin
      m_value = 0;
      m_wcnt  = 0;
    end else if (ld) begin
      if (lv < M) m_value = lv;
      else begin
        m_value = M - 1;
        e.err   = 1;
      end
    end else if (nw) begin
      if (st >= M) e.err = 1;
      else if (st > 0) begin
        s = d ? m_value + st : m_value - st;
        if (s >= 0 && s < M) m_value = s;
        else if (!md) begin
          m_value = (s + M) % M;
          e.wrap  = 1;
          m_wcnt  = (m_wcnt + 1) % (1 << WW);
        end else begin
          m_value = (s < 0) ? 0 : M - 1;
          e.sat   = 1;
        end
      end
    end
    e.value = m_value;
    e.wcnt  = m_wcnt;
    e.tc    = d ? (m_value == M - 1) : (m_value == 0);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit c, input bit ld, input int lv, input bit nw,
                     input bit d, input bit md, input int st);
    @(negedge clk);
    apply(c, ld, lv, nw, d, md, st);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: the counter presents a result every edge; pop one expectation per edge.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        n_vec++;
        ok = (int'(bus.value) == e.value) && (bus.wrap == e.wrap) && (bus.sat == e.sat) &&
             (bus.err == e.err) && (bus.tc == e.tc) && (int'(bus.wrap_cnt) == e.wcnt);
        if (!ok) begin
          n_bad++;
          $display("FAIL txn %0d: got v=%0d w=%b s=%b e=%b tc=%b wc=%0d, required v=%0d w=%b s=%b e=%b tc=%b wc=%0d",
                   n_txn, bus.value, bus.wrap, bus.sat, bus.err, bus.tc, bus.wrap_cnt,
                   e.value, e.wrap, e.sat, e.err, e.tc, e.wcnt);
        end else begin
          $display("txn %0d: v=%0d w=%b s=%b e=%b tc=%b wc=%0d",
                   n_txn, bus.value, bus.wrap, bus.sat, bus.err, bus.tc, bus.wrap_cnt);
        end
      end
    end
  end

  initial begin
    bus.clr = 0; bus.load = 0; bus.load_val = '0; bus.now = 0;
    bus.dir = DIR_DOWN; bus.mode = MODE_WRAP; bus.step = '0;
    #1 rst = 1'b1;
    #11;
    check("reset_value", int'(bus.value), 0);
    check("reset_wrap_cnt", int'(bus.wrap_cnt), 0);
    check("reset_pulses", int'({bus.wrap, bus.sat, bus.err}), 0);
    check("reset_tc_down", int'(bus.tc), 1);

    // Up count by 1 in wrap mode across the 6->0 boundary
    @(negedge clk);
    rst = 1'b0;
    m_value = 0;
    m_wcnt  = 0;
    apply(0, 0, 0, 1, 1, 0, 1);
    repeat (8) cyc(0, 0, 0, 1, 1, 0, 1);
    settle();
    check("up_value", int'(bus.value), 2);
    check("up_wrap_cnt", int'(bus.wrap_cnt), 1);

    // Clear, load 1, count down by 3 in wrap mode
    cyc(1, 0, 0, 0, 0, 0, 3);
    cyc(0, 1, 1, 0, 0, 0, 3);
    repeat (4) cyc(0, 0, 0, 1, 0, 0, 3);
    settle();
    check("down_value", int'(bus.value), 3);
    check("down_wrap_cnt", int'(bus.wrap_cnt), 2);

    // Saturate up by 2 from 4
    cyc(0, 1, 4, 0, 1, 1, 2);
    repeat (3) cyc(0, 0, 0, 1, 1, 1, 2);
    settle();
    check("sat_value", int'(bus.value), 6);
    check("sat_pulse", int'(bus.sat), 1);
    check("sat_no_wrap", int'(bus.wrap), 0);

    // Load beats count; illegal load clamps with err
    cyc(0, 1, 5, 1, 1, 0, 1);
    settle();
    check("load_prio_value", int'(bus.value), 5);
    cyc(0, 1, 7, 0, 1, 0, 1);
    settle();
    check("bad_load_value", int'(bus.value), 6);
    check("bad_load_err", int'(bus.err), 1);
    cyc(0, 0, 0, 0, 1, 0, 1);
    settle();
    check("err_one_cycle", int'(bus.err), 0);

    // Zero step holds quietly; step=MODULUS holds with err
    repeat (2) cyc(0, 0, 0, 1, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 1, 0, 7);
    settle();
    check("bad_step_value", int'(bus.value), 6);
    check("bad_step_err", int'(bus.err), 1);

    // Asynchronous reset while counting up at value 4
    cyc(0, 1, 3, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 1, 0, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_value", int'(bus.value), 0);
    check("async_rst_wrap_cnt", int'(bus.wrap_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    m_value = 0;
    m_wcnt  = 0;
    apply(0, 0, 0, 1, 1, 0, 1);
    repeat (3) cyc(0, 0, 0, 1, 1, 0, 1);
    settle();
    check("resume_value", int'(bus.value), 4);

    // Random traffic against the model
    repeat (400) begin
      int r;
      r = int'($urandom_range(0, 99));
      cyc(r < 3, (r >= 3) && (r < 10), int'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end

    @(negedge clk);
    bus.now = 0; bus.load = 0; bus.clr = 0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
